// File: rtl/i2c_target.sv
// i2c_target: I2C target (slave) endpoint bridging the bus to a req/ack register port.
//
// An external controller reads and writes an 8-bit register space through an
// auto-incrementing pointer. The first byte after a write-addressing phase
// loads the pointer, and later bytes are written there. A read-addressing
// phase streams bytes fetched from the register port.
//
// Optional build macro: I2C_STRETCH_EN
//   defined   - a late read fetch holds SCL low until the data arrives.
//   undefined - sclout is tied high. A late fetch sends 8'hFF and pulses err.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   scl, sdain      raw pad inputs (asynchronous)
//   sdaout, sclout  open-drain drives (1 = release, 0 = pull low)
//   regaddr, regwrdata, regreq, regwr   register request (held until regack)
//   regrddata, regack                   register completion (one-cycle strobe)
//   busy            addressed, from address match until STOP/START
//   err             one-cycle pulse on a dropped write or a late read
module i2c_target #(
    parameter logic [6:0] ADDR = 7'h3C,
    parameter int         FILT = 4,
    parameter int         HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl,
    input  logic       sdain,
    output logic       sdaout,
    output logic       sclout,
    output logic [7:0] regaddr,
    output logic [7:0] regwrdata,
    output logic       regreq,
    output logic       regwr,
    input  logic [7:0] regrddata,
    input  logic       regack,
    output logic       busy,
    output logic       err
);
    localparam int FW = (FILT > 1) ? $clog2(FILT) : 1;
    localparam int HW = $clog2(HOLD + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_ADDRACK, S_PTR, S_PTRACK,
        S_WRDATA, S_WRACK, S_RDDATA, S_RDACK, S_IGNORE
    } state_t;

    // Index 0 = SCL, index 1 = SDA. Both lines use the same path so that
    // their relative ordering is preserved for START/STOP detection.
    logic [1:0] raw_w, filt_w, filt_dly_w;
    assign raw_w = {sdain, scl};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_filt
            logic          sync1_q, sync2_q, filt_q, filt_dly_q;
            logic [FW-1:0] cnt_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    sync1_q    <= 1'b1;
                    sync2_q    <= 1'b1;
                    filt_q     <= 1'b1;
                    filt_dly_q <= 1'b1;
                    cnt_q      <= '0;
                end else begin
                    sync1_q    <= raw_w[gi];
                    sync2_q    <= sync1_q;
                    filt_dly_q <= filt_q;
                    // Flip only after FILT consecutive samples disagree.
                    if (sync2_q == filt_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == FW'(FILT - 1)) begin
                        filt_q <= sync2_q;
                        cnt_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
            end
            assign filt_w[gi]     = filt_q;
            assign filt_dly_w[gi] = filt_dly_q;
        end
    endgenerate

    logic scl_rise, scl_fall, start_c, stop_c, sda_bit;
    assign scl_rise = filt_w[0] & ~filt_dly_w[0];
    assign scl_fall = ~filt_w[0] & filt_dly_w[0];
    assign start_c  = filt_w[0] & ~filt_w[1] & filt_dly_w[1];
    assign stop_c   = filt_w[0] & filt_w[1] & ~filt_dly_w[1];
    assign sda_bit  = filt_w[1];

    state_t        state_q, state_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [6:0]    shift_q, shift_d;
    logic [7:0]    tx_q, tx_d, ptr_q, ptr_d;
    logic [7:0]    regaddr_q, regaddr_d, regwrdata_q, regwrdata_d;
    logic          rw_q, rw_d, nack_q, nack_d, regreq_q, regreq_d, regwr_q, regwr_d;
    logic          busy_q, busy_d, err_q, err_d, sdaout_q, sdaout_d;
    logic          dv_q, dv_d;               // read data for the next byte is in tx_q
    logic [HW-1:0] hold_q, hold_d;
`ifdef I2C_STRETCH_EN
    logic          sclout_q, sclout_d, setup_q, setup_d;
`else
    logic          discard_q, discard_d;     // a late regack's data must be dropped
`endif

    logic [7:0] rx_byte;
    logic       rd_fire, first_bit, data_ready, sda_want;
    assign rx_byte    = {shift_q, sda_bit};
    assign rd_fire    = regack & regreq_q & ~regwr_q;
    assign first_bit  = (state_q == S_RDDATA) && (bitcnt_q == 3'd0);
    assign data_ready = dv_q | rd_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;   bitcnt_q <= '0;    shift_q <= '0;    tx_q <= '0;
            ptr_q <= '0;         regaddr_q <= '0;   regwrdata_q <= '0;
            rw_q <= 1'b0;        nack_q <= 1'b0;    regreq_q <= 1'b0; regwr_q <= 1'b0;
            busy_q <= 1'b0;      err_q <= 1'b0;     sdaout_q <= 1'b1; dv_q <= 1'b0;
            hold_q <= '0;
`ifdef I2C_STRETCH_EN
            sclout_q <= 1'b1;    setup_q <= 1'b0;
`else
            discard_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;  bitcnt_q <= bitcnt_d; shift_q <= shift_d; tx_q <= tx_d;
            ptr_q <= ptr_d;      regaddr_q <= regaddr_d; regwrdata_q <= regwrdata_d;
            rw_q <= rw_d;        nack_q <= nack_d;   regreq_q <= regreq_d; regwr_q <= regwr_d;
            busy_q <= busy_d;    err_q <= err_d;     sdaout_q <= sdaout_d; dv_q <= dv_d;
            hold_q <= hold_d;
`ifdef I2C_STRETCH_EN
            sclout_q <= sclout_d; setup_q <= setup_d;
`else
            discard_q <= discard_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;   bitcnt_d = bitcnt_q;   shift_d = shift_q;   tx_d = tx_q;
        ptr_d = ptr_q;       regaddr_d = regaddr_q; regwrdata_d = regwrdata_q;
        rw_d = rw_q;         nack_d = nack_q;       regreq_d = regreq_q; regwr_d = regwr_q;
        busy_d = busy_q;     err_d = 1'b0;          sdaout_d = sdaout_q; dv_d = dv_q;
        hold_d = hold_q;     sda_want = 1'b1;
`ifdef I2C_STRETCH_EN
        sclout_d = sclout_q; setup_d = setup_q;
`else
        discard_d = discard_q;
`endif

        // Register handshake completion.
        if (regack && regreq_q) regreq_d = 1'b0;
        if (rd_fire) begin
`ifdef I2C_STRETCH_EN
            tx_d = regrddata;
            dv_d = 1'b1;
`else
            if (discard_q) begin
                discard_d = 1'b0;
            end else begin
                tx_d = regrddata;
                dv_d = 1'b1;
            end
`endif
        end

        // tHD;DAT timer: SDA may only move when this reaches 1.
        if (scl_fall)            hold_d = HW'(HOLD);
        else if (hold_q != '0)   hold_d = hold_q - 1'b1;

`ifndef I2C_STRETCH_EN
        // Fetch missed the end of the ACK bit: send all-ones instead.
        if (scl_fall && first_bit && !data_ready) begin
            tx_d = 8'hFF; dv_d = 1'b1; err_d = 1'b1; discard_d = 1'b1;
        end
`endif

        case (state_q)
            S_ADDRACK, S_PTRACK: sda_want = 1'b0;
            S_WRACK:             sda_want = nack_q;
            S_RDDATA:            sda_want = tx_d[7];
            default:             sda_want = 1'b1;
        endcase

        if (hold_q == HW'(1)) begin
`ifdef I2C_STRETCH_EN
            if (first_bit && !data_ready) sclout_d = 1'b0;
            else                          sdaout_d = sda_want;
`else
            sdaout_d = sda_want;
`endif
        end

`ifdef I2C_STRETCH_EN
        // While stretching: put the first bit on SDA, then free SCL a cycle later.
        if (!sclout_q) begin
            if (setup_q) begin
                sclout_d = 1'b1;
                setup_d  = 1'b0;
            end else if (dv_q) begin
                sdaout_d = tx_q[7];
                setup_d  = 1'b1;
            end
        end
`endif

        if (scl_rise) begin
            case (state_q)
                S_ADDR: begin
                    shift_d  = rx_byte[6:0];
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        if (rx_byte[7:1] == ADDR) begin
                            busy_d  = 1'b1;
                            rw_d    = rx_byte[0];
                            state_d = S_ADDRACK;
                        end else begin
                            state_d = S_IGNORE;
                        end
                    end
                end
                S_ADDRACK: begin
                    bitcnt_d = 3'd0;
                    if (rw_q) begin
                        regreq_d = 1'b1; regwr_d = 1'b0; regaddr_d = ptr_q;
                        ptr_d = ptr_q + 8'd1; dv_d = 1'b0;
                        state_d = S_RDDATA;
                    end else begin
                        state_d = S_PTR;
                    end
                end
                S_PTR: begin
                    shift_d  = rx_byte[6:0];
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        ptr_d   = rx_byte;
                        state_d = S_PTRACK;
                    end
                end
                S_PTRACK, S_WRACK: begin
                    bitcnt_d = 3'd0;
                    state_d  = S_WRDATA;
                end
                S_WRDATA: begin
                    shift_d  = rx_byte[6:0];
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        if (!regreq_q) begin
                            regreq_d = 1'b1; regwr_d = 1'b1; regaddr_d = ptr_q;
                            regwrdata_d = rx_byte; ptr_d = ptr_q + 8'd1; nack_d = 1'b0;
                        end else begin
                            nack_d = 1'b1;
                            err_d  = 1'b1;
                        end
                        state_d = S_WRACK;
                    end
                end
                S_RDDATA: begin
                    tx_d     = {tx_q[6:0], 1'b1};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = S_RDACK;
                end
                S_RDACK: begin
                    bitcnt_d = 3'd0;
                    if (!sda_bit) begin
                        regreq_d = 1'b1; regwr_d = 1'b0; regaddr_d = ptr_q;
                        ptr_d = ptr_q + 8'd1; dv_d = 1'b0;
                        state_d = S_RDDATA;
                    end else begin
                        state_d = S_IGNORE;
                    end
                end
                default: ;
            endcase
        end

        // START/STOP win over everything else; an in-flight regreq is left alone.
        if (start_c || stop_c) begin
            state_d  = start_c ? S_ADDR : S_IDLE;
            bitcnt_d = 3'd0;
            sdaout_d = 1'b1;
            busy_d   = 1'b0;
            hold_d   = '0;
`ifdef I2C_STRETCH_EN
            sclout_d = 1'b1;
            setup_d  = 1'b0;
`endif
        end
    end

    assign sdaout    = sdaout_q;
    assign regaddr   = regaddr_q;
    assign regwrdata = regwrdata_q;
    assign regreq    = regreq_q;
    assign regwr     = regwr_q;
    assign busy      = busy_q;
    assign err       = err_q;
`ifdef I2C_STRETCH_EN
    assign sclout    = sclout_q;
`else
    assign sclout    = 1'b1;
`endif

endmodule

// File: tb/tb_i2c_target.sv
`timescale 1ns/1ps
module tb_i2c_target;
    localparam int Q = 20;   // quarter SCL period in clk cycles

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1, sda_m = 1'b1;
    logic       sdaout, sclout, regreq, regwr, busy, err;
    logic [7:0] regaddr, regwrdata;
    logic [7:0] regrddata = 8'h00;
    logic       regack = 1'b0;
    wire        scl_bus = scl_m & sclout;
    wire        sda_bus = sda_m & sdaout;

    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    i2c_target dut (
        .clk(clk), .rst(rst), .scl(scl_bus), .sdain(sda_bus),
        .sdaout(sdaout), .sclout(sclout), .regaddr(regaddr), .regwrdata(regwrdata),
        .regreq(regreq), .regwr(regwr), .regrddata(regrddata), .regack(regack),
        .busy(busy), .err(err)
    );

    // Register-side responder and request log.
    logic [7:0] mem [0:255];
    int         ack_delay = 3;
    int         resp_cnt = 0;
    bit         resp_busy = 0;
    int         log_n = 0;
    logic       log_wr   [0:63];
    logic [7:0] log_addr [0:63];
    logic [7:0] log_data [0:63];

    always @(negedge clk) begin
        regack = 1'b0;
        if (rst) begin
            resp_busy = 0;
        end else if (resp_busy) begin
            if (resp_cnt <= 1) begin
                regack    = 1'b1;
                regrddata = mem[regaddr];
                resp_busy = 0;
                $display("txn ack %s addr=0x%02h rddata=0x%02h", regwr ? "wr" : "rd", regaddr, mem[regaddr]);
            end else begin
                resp_cnt--;
            end
        end else if (regreq) begin
            resp_busy = 1;
            resp_cnt  = ack_delay;
            if (log_n < 64) begin
                log_wr[log_n] = regwr; log_addr[log_n] = regaddr; log_data[log_n] = regwrdata;
            end
            log_n++;
            $display("txn req %s addr=0x%02h wrdata=0x%02h", regwr ? "wr" : "rd", regaddr, regwrdata);
        end
    end

    int err_cnt = 0;
    bit scl_low_seen = 0, sda_low_seen = 0, busy_seen = 0;
    always @(negedge clk) begin
        if (err)     err_cnt++;
        if (!sclout) scl_low_seen = 1;
        if (!sdaout) sda_low_seen = 1;
        if (busy)    busy_seen = 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: time=%0t limit=%0t", $time, 2ms);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic raise_scl();
        int t = 0;
        scl_m = 1'b1;
        while (scl_bus !== 1'b1 && t < 3000) begin wait_clk(1); t++; end
        if (scl_bus !== 1'b1) check("scl_release_timeout", scl_bus, 1);
    endtask

    task automatic write_bit(input logic b);
        wait_clk(Q); sda_m = b; wait_clk(Q);
        raise_scl(); wait_clk(2 * Q); scl_m = 1'b0;
    endtask

    task automatic read_bit(output logic b);
        wait_clk(Q); sda_m = 1'b1; wait_clk(Q);
        raise_scl(); wait_clk(Q); b = sda_bus; wait_clk(Q); scl_m = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        read_bit(ack);
        $display("i2c wr byte=0x%02h nack=%0b", b, ack);
    endtask

    task automatic read_byte(output logic [7:0] d, input logic nack);
        logic bt;
        for (int i = 7; i >= 0; i--) begin read_bit(bt); d[i] = bt; end
        write_bit(nack);
        $display("i2c rd byte=0x%02h nack=%0b", d, nack);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; scl_m = 1'b1; wait_clk(Q);
        sda_m = 1'b0; wait_clk(2 * Q); scl_m = 1'b0;
    endtask

    task automatic i2c_rstart();
        wait_clk(Q); sda_m = 1'b1; wait_clk(Q);
        raise_scl(); wait_clk(Q); sda_m = 1'b0; wait_clk(Q); scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(Q); sda_m = 1'b0; wait_clk(Q);
        raise_scl(); wait_clk(Q); sda_m = 1'b1; wait_clk(2 * Q);
    endtask

    task automatic wait_req_idle();
        int t = 0;
        while (regreq && t < 3000) begin wait_clk(1); t++; end
        if (regreq) check("req_idle_timeout", regreq, 0);
    endtask

    task automatic check_wr_log(input string tag, input int idx, input logic [7:0] a, input logic [7:0] d);
        check({tag, "_wr"},   log_wr[idx],   1);
        check({tag, "_addr"}, log_addr[idx], a);
        check({tag, "_data"}, log_data[idx], d);
    endtask

    task automatic check_rd_log(input string tag, input int idx, input logic [7:0] a);
        check({tag, "_wr"},   log_wr[idx],   0);
        check({tag, "_addr"}, log_addr[idx], a);
    endtask

    initial begin
        logic       a0, a1, a2, a3;
        logic [7:0] d0, d1, d2, addr_w;
        int         lb, eb;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h20] = 8'hC3; mem[8'h21] = 8'h3C; mem[8'h22] = 8'h96; mem[8'h30] = 8'h6B;

        rst = 1'b1; wait_clk(4); rst = 1'b0; wait_clk(2);
        check("rst_sdaout", sdaout, 1);
        check("rst_sclout", sclout, 1);
        check("rst_regreq", regreq, 0);
        check("rst_regwr", regwr, 0);
        check("rst_regaddr", regaddr, 0);
        check("rst_regwrdata", regwrdata, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);

        // Write two bytes starting at 0x10.
        lb = log_n; eb = err_cnt;
        i2c_start();
        write_byte(8'h78, a0); write_byte(8'h10, a1);
        check("t1_busy_mid", busy, 1);
        write_byte(8'hA5, a2); write_byte(8'h5A, a3);
        i2c_stop(); wait_clk(10);
        check("t1_ack", {a0, a1, a2, a3}, 4'b0000);
        check("t1_busy_after", busy, 0);
        check("t1_nreq", log_n - lb, 2);
        check_wr_log("t1_w0", lb, 8'h10, 8'hA5);
        check_wr_log("t1_w1", lb + 1, 8'h11, 8'h5A);
        check("t1_err", err_cnt - eb, 0);

        // Read three bytes from 0x20, last NACKed.
        lb = log_n; eb = err_cnt;
        i2c_start();
        write_byte(8'h78, a0); write_byte(8'h20, a1);
        i2c_rstart();
        write_byte(8'h79, a2);
        read_byte(d0, 1'b0); read_byte(d1, 1'b0); read_byte(d2, 1'b1);
        i2c_stop(); wait_clk(10);
        check("t2_ack", {a0, a1, a2}, 3'b000);
        check("t2_d0", d0, 8'hC3);
        check("t2_d1", d1, 8'h3C);
        check("t2_d2", d2, 8'h96);
        check("t2_nreq", log_n - lb, 3);
        check_rd_log("t2_r0", lb, 8'h20);
        check_rd_log("t2_r1", lb + 1, 8'h21);
        check_rd_log("t2_r2", lb + 2, 8'h22);
        check("t2_err", err_cnt - eb, 0);

        // Wrong address.
        lb = log_n; sda_low_seen = 0; busy_seen = 0;
        i2c_start();
        write_byte(8'h50, a0);
        i2c_stop(); wait_clk(10);
        check("t3_nack", a0, 1);
        check("t3_nreq", log_n - lb, 0);
        check("t3_busy_seen", busy_seen, 0);
        check("t3_sda_low_seen", sda_low_seen, 0);

        // Pointer wrap 0xFF -> 0x00.
        lb = log_n;
        i2c_start();
        write_byte(8'h78, a0); write_byte(8'hFF, a1);
        write_byte(8'h11, a2); write_byte(8'h22, a3);
        i2c_stop(); wait_clk(10);
        check("t4_ack", {a0, a1, a2, a3}, 4'b0000);
        check("t4_nreq", log_n - lb, 2);
        check_wr_log("t4_w0", lb, 8'hFF, 8'h11);
        check_wr_log("t4_w1", lb + 1, 8'h00, 8'h22);

        // Write while the previous request is still pending.
        lb = log_n; eb = err_cnt; ack_delay = 1000;
        i2c_start();
        write_byte(8'h78, a0); write_byte(8'h40, a1);
        write_byte(8'h77, a2); write_byte(8'h88, a3);
        i2c_stop();
        wait_req_idle(); wait_clk(10);
        ack_delay = 3;
        check("t5_ack", {a0, a1, a2}, 3'b000);
        check("t5_nack2", a3, 1);
        check("t5_err", err_cnt - eb, 1);
        check("t5_nreq", log_n - lb, 1);
        check_wr_log("t5_w0", lb, 8'h40, 8'h77);

        // Read with a 200-cycle fetch latency.
        lb = log_n; eb = err_cnt; ack_delay = 200; scl_low_seen = 0;
        i2c_start();
        write_byte(8'h78, a0); write_byte(8'h30, a1);
        i2c_rstart();
        write_byte(8'h79, a2);
        read_byte(d0, 1'b1);
        i2c_stop();
        wait_req_idle(); wait_clk(10);
        ack_delay = 3;
        check("t6_ack", {a0, a1, a2}, 3'b000);
        check("t6_nreq", log_n - lb, 1);
        check_rd_log("t6_r0", lb, 8'h30);
`ifdef I2C_STRETCH_EN
        check("t6_data", d0, 8'h6B);
        check("t6_err", err_cnt - eb, 0);
        check("t6_stretched", scl_low_seen, 1);
`else
        check("t6_data", d0, 8'hFF);
        check("t6_err", err_cnt - eb, 1);
        check("t6_stretched", scl_low_seen, 0);
`endif

        // Reset while the target is driving its address ACK.
        addr_w = 8'h78;
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(addr_w[i]);
        wait_clk(Q + 5);
        check("t7_ack_driven", sdaout, 0);
        check("t7_busy_pre", busy, 1);
        rst = 1'b1; wait_clk(1);
        check("t7_rst_sdaout", sdaout, 1);
        check("t7_rst_busy", busy, 0);
        check("t7_rst_regreq", regreq, 0);
        rst = 1'b0;
        sda_m = 1'b0; wait_clk(Q); scl_m = 1'b1; wait_clk(Q); sda_m = 1'b1; wait_clk(2 * Q);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (slave) endpoint. It is the responder for the same bus our i2c master drives.
- Lets an external controller (bench host, second FPGA, debug dongle) read and write an internal 8-bit register space over SCL/SDA.
- Converts bus transactions into the same req/ack register handshake used by i2carb/hdmi, with an auto-incrementing register pointer.
- SDA is open-drain through an IOBUF at top level: sdaout=1 releases, sdaout=0 drives low.

Parameters:
- ADDR, 7'h3C, 7-bit target address matched after START.
- FILT, 4, glitch filter depth in clk cycles; the filtered line changes only after FILT consecutive equal samples.
- HOLD, 8, clk cycles after a filtered SCL fall before sdaout may change (tHD;DAT).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- scl  input  1  raw SCL from pad (asynchronous)
- sdain  input  1  raw SDA from pad (asynchronous)
- sdaout  output  1  SDA drive; 1=release, 0=pull low
- sclout  output  1  SCL drive for clock stretching; 1=release
- regaddr  output  8  register address of the current access
- regwrdata  output  8  write data
- regreq  output  1  access request; held until regack
- regwr  output  1  1=write, 0=read; valid while regreq
- regrddata  input  8  read data; valid in the cycle regack=1
- regack  input  1  one-cycle completion strobe
- busy  output  1  high from address match until STOP/START
- err  output  1  one-cycle pulse on dropped write or late read data

Behaviour:
- Reset values: sdaout=1, sclout=1, regreq=0, regwr=0, regaddr=0, regwrdata=0, busy=0, err=0, state IDLE, pointer 0.
- Input path: 2-flop synchronizer on scl and sdain, then FILT-deep filter. Edges are detected on the filtered signals, delayed 1 clk.
- START = filtered SDA falls while SCL high. STOP = SDA rises while SCL high. Both take effect from any state.
- START (including repeated START) -> ADDR, bit count reset, sdaout=1.
- STOP -> IDLE, sdaout=1, busy=0. An outstanding regreq still completes.
- SDA is sampled on the filtered SCL rising edge, MSB first.
- sdaout changes only HOLD cycles after a filtered SCL fall. It is never changed while SCL is high.
- States: IDLE, ADDR, ADDRACK, PTR, PTRACK, WRDATA, WRACK, RDDATA, RDACK, IGNORE.
- ADDR: 8 bits. If [7:1]==ADDR: busy=1, -> ADDRACK (drive 0 for one SCL period). Then R/W=0 -> PTR; R/W=1 -> issue fetch, -> RDDATA. On mismatch -> IGNORE (stay released until START/STOP).
- PTR: the byte loads the pointer, is ACKed, -> WRDATA.
- WRDATA: on byte complete, if regreq is idle: regreq=1, regwr=1, regaddr=pointer, regwrdata=byte, pointer+1, ACK. If regreq is still pending: drop the byte, NACK, err pulse, pointer unchanged. -> WRACK -> WRDATA.
- Fetch:
  - regreq=1, regwr=0, regaddr=pointer, pointer+1.
  - Issued on the SCL rise of the ACK bit preceding the byte (our ACK for the address, the master's ACK for subsequent bytes).
  - Data is latched into the shift register on regack.
- RDDATA: shift out 8 bits, then release for RDACK.
  - Master ACK (SDA=0) -> fetch next byte, -> RDDATA.
  - Master NACK -> IGNORE.
- Pointer is 8 bits and wraps 0xFF -> 0x00.
- regreq deasserts in the cycle after regack. regack while regreq=0 is ignored.
- Reset mid-transfer: all outputs return to reset values on the next clk. The bus is released immediately.

Optional Feature:
- Macro I2C_STRETCH_EN.
- Defined: if fetch data has not arrived by the SCL fall ending the ACK bit, hold sclout=0 from HOLD cycles after that fall until regack. Release sclout 1 clk after the data is latched and the first bit is set up on sdaout. No err is raised.
- Undefined: sclout is constant 1. If regack has not arrived by that fall, the byte is sent as 8'hFF and err pulses once. The late regack still completes the handshake, but its data is discarded.

Test Plan:
- Write: S 0x78 ptr=0x10 data 0xA5 0x5A P -> two writes (0x10,0xA5), (0x11,0x5A); every byte ACKed; busy low after STOP.
- Read, regack 3 clk after regreq: S 0x78 0x20, Sr 0x79, read 3 bytes, last NACKed -> reads of 0x20/0x21/0x22 return their regrddata; fourth fetch never issued.
- Wrong address 0x50 on the bus -> no ACK, no regreq, busy stays 0, sdaout=1 throughout.
- Pointer 0xFF, write 2 bytes -> addresses 0xFF then 0x00.
- Write with regack withheld for a full byte period -> second byte NACKed, err pulses once, no extra regreq.
- regack delayed 200 clk on a read:
  - With I2C_STRETCH_EN: sclout low until regack, correct byte returned.
  - Without it: byte 0xFF, one err pulse.
